// File: rtl/cache_fill_fsm.sv
// Cache line fill sequencer: on a miss, issues eight 16-bit reads for the aligned 16-byte block
// and writes each returned word, then the tag. Optional watchdog: define CACHE_FILL_TIMEOUT_EN.
module cache_fill_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        memory_data_valid,
  output logic        fsm_busy,
  output logic        mem_req,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic [15:0] write_addr,
  output logic        write_tag_array,
  output logic        fill_error
);

  typedef enum logic [0:0] {
    StIdle,
    StFill
  } state_e;

  localparam logic [3:0] BlockWords = 4'd8;

  state_e      r_state, w_state_next;
  logic [15:0] r_base, w_base_next;
  logic [3:0]  r_issue, w_issue_next;
  logic [3:0]  r_recv, w_recv_next;
  logic        w_timeout;
  logic [15:0] w_issue_addr;
  logic [15:0] w_recv_addr;

`ifdef CACHE_FILL_TIMEOUT_EN
  logic [4:0]  r_wdog, w_wdog_next;
`endif

  // Offsets are spliced into the aligned base so they can never carry out of the block.
  assign w_issue_addr = {r_base[15:4], r_issue[2:0], 1'b0};
  assign w_recv_addr  = {r_base[15:4], r_recv[2:0], 1'b0};

  always_comb begin
    w_state_next     = r_state;
    w_base_next      = r_base;
    w_issue_next     = r_issue;
    w_recv_next      = r_recv;
    w_timeout        = 1'b0;
    fsm_busy         = 1'b0;
    mem_req          = 1'b0;
    memory_address   = 16'h0000;
    write_data_array = 1'b0;
    write_addr       = 16'h0000;
    write_tag_array  = 1'b0;
    fill_error       = 1'b0;
`ifdef CACHE_FILL_TIMEOUT_EN
    w_wdog_next      = r_wdog;
`endif

    unique case (r_state)
      StIdle: begin
        if (miss_detected) begin
          w_state_next = StFill;
          w_base_next  = miss_address & 16'hFFF0;
          w_issue_next = 4'd0;
          w_recv_next  = 4'd0;
`ifdef CACHE_FILL_TIMEOUT_EN
          w_wdog_next  = 5'd0;
`endif
        end
      end

      StFill: begin
        fsm_busy = 1'b1;
`ifdef CACHE_FILL_TIMEOUT_EN
        w_timeout   = (r_wdog == 5'd16);
        fill_error  = w_timeout;
        w_wdog_next = memory_data_valid ? 5'd0 : r_wdog + 5'd1;
`endif
        if (r_issue < BlockWords) begin
          mem_req        = 1'b1;
          memory_address = w_issue_addr;
          w_issue_next   = r_issue + 4'd1;
        end
        if (r_recv < BlockWords) begin
          write_addr = w_recv_addr;
          if (memory_data_valid) begin
            write_data_array = 1'b1;
            w_recv_next      = r_recv + 4'd1;
            if (r_recv == BlockWords - 4'd1) begin
              write_tag_array = ~w_timeout;
              w_state_next    = StIdle;
            end
          end
        end
        if (w_timeout) begin
          w_state_next = StIdle;
        end
      end

      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_base  <= 16'h0000;
      r_issue <= 4'd0;
      r_recv  <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_base  <= w_base_next;
      r_issue <= w_issue_next;
      r_recv  <= w_recv_next;
    end
  end

`ifdef CACHE_FILL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog <= 5'd0;
    end else begin
      r_wdog <= w_wdog_next;
    end
  end
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: directed fill scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = 16'h0000;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy, mem_req, write_data_array, write_tag_array, fill_error;
  logic [15:0] memory_address, write_addr;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

`ifdef CACHE_FILL_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  // Model: is a fill open, its block base, words requested, words returned, quiet cycles.
  bit          m_fill = 1'b0;
  logic [15:0] m_base = 16'h0000;
  int          m_iss = 0;
  int          m_rcv = 0;
  int          m_quiet = 0;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_req           (mem_req),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .write_addr        (write_addr),
    .write_tag_array   (write_tag_array),
    .fill_error        (fill_error)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit n_fill;
    int n_iss, n_rcv, n_quiet;
    logic [15:0] n_base;
    bit timed_out;
    n_fill = m_fill; n_base = m_base; n_iss = m_iss; n_rcv = m_rcv; n_quiet = m_quiet;
    if (rst) begin
      n_fill = 1'b0; n_base = 16'h0000; n_iss = 0; n_rcv = 0; n_quiet = 0;
      chk_en <= 1'b1;
    end else if (!m_fill) begin
      if (miss_detected) begin
        n_fill = 1'b1; n_base = miss_address & 16'hFFF0; n_iss = 0; n_rcv = 0; n_quiet = 0;
      end
    end else begin
      timed_out = ToEn && (m_quiet >= 16);
      if (m_iss < 8) n_iss = m_iss + 1;
      if (memory_data_valid && m_rcv < 8) n_rcv = m_rcv + 1;
      n_quiet = memory_data_valid ? 0 : m_quiet + 1;
      if (n_rcv == 8 || timed_out) n_fill = 1'b0;
    end
    m_fill <= n_fill; m_base <= n_base; m_iss <= n_iss; m_rcv <= n_rcv; m_quiet <= n_quiet;
  end

  always @(negedge clk) begin
    logic e_req, e_wda, e_to, e_tag;
    logic [15:0] e_maddr, e_waddr;
    if (chk_en) begin
      e_req   = m_fill && (m_iss < 8);
      e_maddr = e_req ? 16'(m_base + 2 * m_iss) : 16'h0000;
      e_wda   = m_fill && memory_data_valid && (m_rcv < 8);
      e_waddr = m_fill ? 16'(m_base + 2 * m_rcv) : 16'h0000;
      e_to    = ToEn && m_fill && (m_quiet >= 16);
      e_tag   = e_wda && (m_rcv == 7) && !e_to;
      check("m_busy", 16'(fsm_busy), 16'(m_fill));
      check("m_mem_req", 16'(mem_req), 16'(e_req));
      if (!m_fill || e_req) check("m_memory_address", memory_address, e_maddr);
      check("m_write_data", 16'(write_data_array), 16'(e_wda));
      check("m_write_addr", write_addr, e_waddr);
      check("m_write_tag", 16'(write_tag_array), 16'(e_tag));
      check("m_fill_error", 16'(fill_error), 16'(e_to));
    end
  end

  task automatic drive(input bit r, input bit m, input logic [15:0] a, input bit v);
    rst = r; miss_detected = m; miss_address = a; memory_data_valid = v;
    #4;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wcount, nreq, pct;
    drive(1'b1, 1'b0, 16'h0000, 1'b0); next_cycle();
    drive(1'b1, 1'b0, 16'h0000, 1'b0); next_cycle();

    // Basic fill, 4-cycle memory latency.
    for (int t = 0; t <= 14; t++) begin
      drive(1'b0, t == 0, 16'h1236, (t >= 5) && (t <= 12));
      if (t == 0) begin
        check("reset_busy", 16'(fsm_busy), 16'h0);
        check("reset_maddr", memory_address, 16'h0000);
      end
      if (t >= 1 && t <= 8) begin
        check("basic_req", 16'(mem_req), 16'h1);
        check("basic_maddr", memory_address, 16'(16'h1230 + 2 * (t - 1)));
      end
      if (t == 9) check("basic_req_done", 16'(mem_req), 16'h0);
      if (t >= 5 && t <= 12) check("basic_waddr", write_addr, 16'(16'h1230 + 2 * (t - 5)));
      if (t == 11) check("basic_tag_early", 16'(write_tag_array), 16'h0);
      if (t == 12) begin
        check("basic_tag", 16'(write_tag_array), 16'h1);
        check("basic_busy_last", 16'(fsm_busy), 16'h1);
      end
      if (t == 13) check("basic_busy_drop", 16'(fsm_busy), 16'h0);
      next_cycle();
    end

    // Gapped returns.
    wcount = 0;
    for (int t = 0; t <= 22; t++) begin
      drive(1'b0, t == 0, 16'h456A, t inside {5, 6, 9, 10, 11, 15, 16, 20});
      if (write_data_array) begin
        check("gap_waddr", write_addr, 16'(16'h4560 + 2 * wcount));
        wcount++;
      end
      if (t == 19) check("gap_tag_early", 16'(write_tag_array), 16'h0);
      if (t == 20) check("gap_tag", 16'(write_tag_array), 16'h1);
      if (t == 21) check("gap_busy_drop", 16'(fsm_busy), 16'h0);
      next_cycle();
    end
    check("gap_writes", 16'(wcount), 16'd8);

    // Wrap at top of address space, second miss ignored during fill.
    nreq = 0;
    for (int t = 0; t <= 14; t++) begin
      drive(1'b0, (t == 0) || (t == 3), (t == 0) ? 16'hFFFE : 16'h2000, (t >= 5) && (t <= 12));
      if (mem_req) nreq++;
      if (t == 1) check("wrap_first", memory_address, 16'hFFF0);
      if (t == 8) check("wrap_last", memory_address, 16'hFFFE);
      if (t == 12) check("wrap_waddr_last", write_addr, 16'hFFFE);
      next_cycle();
    end
    check("wrap_req_count", 16'(nreq), 16'd8);

    // Reset mid-fill.
    for (int t = 0; t <= 14; t++) begin
      drive(t == 7, t == 0, 16'h1236, (t >= 5) && (t <= 12));
      if (t >= 8 && t <= 12) begin
        check("rst_busy", 16'(fsm_busy), 16'h0);
        check("rst_req", 16'(mem_req), 16'h0);
        check("rst_wda", 16'(write_data_array), 16'h0);
        check("rst_waddr", write_addr, 16'h0000);
        check("rst_tag", 16'(write_tag_array), 16'h0);
      end
      next_cycle();
    end

    // Memory never answers.
`ifdef CACHE_FILL_TIMEOUT_EN
    for (int t = 0; t <= 19; t++) begin
      drive(1'b0, t == 0, 16'h0100, 1'b0);
      if (t == 16) check("to_err_early", 16'(fill_error), 16'h0);
      if (t == 17) check("to_err", 16'(fill_error), 16'h1);
      if (t == 18) begin
        check("to_err_pulse", 16'(fill_error), 16'h0);
        check("to_busy_drop", 16'(fsm_busy), 16'h0);
      end
      next_cycle();
    end
`else
    for (int t = 0; t <= 101; t++) begin
      drive(1'b0, t == 0, 16'h0100, 1'b0);
      if (t == 17) check("noto_err", 16'(fill_error), 16'h0);
      if (t == 101) check("noto_busy", 16'(fsm_busy), 16'h1);
      next_cycle();
    end
`endif
    drive(1'b1, 1'b0, 16'h0000, 1'b0); next_cycle();

    // Randomized traffic; valid density changes every 200 cycles.
    pct = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) pct = (i / 200) % 4 == 3 ? 0 : 20 + 25 * ((i / 200) % 3);
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0, 16'($urandom),
            $urandom_range(0, 99) < pct);
      next_cycle();
    end

    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    next_cycle();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port miss_detected  input  1  pipeline-side miss; sampled only in IDLE.
REQ-004 SHALL have port miss_address  input  16  byte address of the missing access.
REQ-005 SHALL have port memory_data_valid  input  1  memory read data valid this cycle, in issue order.
REQ-006 SHALL have port fsm_busy  output  1  fill in progress; the pipeline stalls on it.
REQ-007 SHALL have port mem_req  output  1  issue one memory read this cycle.
REQ-008 SHALL have port memory_address  output  16  address of the read issued by mem_req.
REQ-009 SHALL have port write_data_array  output  1  write the returned word into the data array.
REQ-010 SHALL have port write_addr  output  16  byte address of the word being written.
REQ-011 SHALL have port write_tag_array  output  1  write the tag and valid bit for the block.
REQ-012 SHALL have port fill_error  output  1  one-cycle pulse when a fill is aborted (see Configuration).

Function
REQ-013 SHALL implement two states: IDLE and FILL.
REQ-014 In IDLE with miss_detected=1, SHALL latch base = miss_address & 16'hFFF0, clear both counters, and enter FILL next cycle.
REQ-015 SHALL assert fsm_busy exactly when the registered state is FILL; the first busy cycle is the one after miss_detected.
REQ-016 In FILL, SHALL keep a 4-bit issue counter (0..8) and a 4-bit receive counter (0..8).
REQ-017 In FILL with issue<8, SHALL assert mem_req combinationally, with memory_address = base + 2*issue; issue increments each such cycle.
REQ-018 In FILL, SHALL drive write_data_array = memory_data_valid combinationally, with write_addr = base + 2*receive; receive increments on each valid.
REQ-019 On the valid that makes receive reach 8 (receive==7 and valid), SHALL assert write_tag_array in that same cycle and return to IDLE next cycle.
REQ-020 SHALL treat memory_data_valid in IDLE, and any valid beyond eight per fill, as don't-care: no write and no counter change.
REQ-021 SHALL ignore miss_detected while in FILL; the next fill can start on the first IDLE cycle.
REQ-022 SHALL compute address offsets modulo 2^16 and never carry out of the 16-byte block (offsets 0..14 only).
REQ-023 In IDLE, mem_req, write_data_array and write_tag_array SHALL be 0, and memory_address and write_addr SHALL be 16'h0000.

Reset
REQ-024 When rst=1 at a clock edge, SHALL enter IDLE, clear base, both counters and the watchdog, and drive every output to 0.
REQ-025 Reset mid-fill SHALL abandon the fill with no write_tag_array; later memory_data_valid pulses fall under REQ-020.

Configuration
REQ-026 Macro CACHE_FILL_TIMEOUT_EN, when defined, SHALL add a 5-bit watchdog in FILL.
  - Cleared on entry to FILL and on every memory_data_valid.
  - Increments on every other FILL cycle.
  - On reaching 16: pulse fill_error for one cycle, suppress write_tag_array, return to IDLE.
REQ-027 Without CACHE_FILL_TIMEOUT_EN, SHALL tie fill_error to 0, have no watchdog, and wait indefinitely in FILL.

Verification
REQ-028 Basic fill: miss_address=16'h1236 at cycle 0, memory with 4-cycle latency.
  - mem_req in cycles 1-8, addresses 16'h1230..16'h123E.
  - write_data_array in cycles 5-12, write_addr 16'h1230..16'h123E.
  - write_tag_array in cycle 12; fsm_busy high in cycles 1-12 and low in cycle 13.
REQ-029 Gapped returns: valids at cycles 5,6,9,10,11,15,16,20 -> eight writes in order, write_tag_array at cycle 20, busy drops at cycle 21.
REQ-030 Wrap and ignore: miss_address=16'hFFFE -> addresses 16'hFFF0..16'hFFFE; a second miss_detected during FILL -> no effect and no extra mem_req.
REQ-031 Reset mid-fill: rst at cycle 7 of REQ-028 -> all outputs 0 from cycle 8; valids at cycles 8-12 -> no write_data_array.
REQ-032 With CACHE_FILL_TIMEOUT_EN: memory never returns data -> fill_error pulse 16 FILL cycles after entry, write_tag_array never set, IDLE next cycle. Without the macro: fsm_busy stays 1 after 100 cycles.
